multicycle_controller: RTL

Parametrised multi-cycle successor to the single-cycle combinational decoder for the 6-bit-opcode accumulator CPU. An FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with ready handshakes to instruction and data memory. It holds architectural C/Z flags internally and tracks return-stack occupancy, with overflow/underflow and illegal-opcode detection. It sits between the datapath (ALU, shifter, register file, PC, return stack) and the two memory ports.

---
 rtl/multicycle_controller_pkg.sv | 39 +++
 rtl/multicycle_controller_if.sv | 12 +
 rtl/multicycle_controller_stack_tracker.sv | 29 ++
 rtl/multicycle_controller.sv | 120 ++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// ctrl_pkg: opcode classes, encodings and one-hot select constants for the multicycle controller
package ctrl_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_e;
  typedef enum logic [3:0] {CL_R, CL_I, CL_SHF, CL_LDM, CL_STM, CL_BR, CL_JMP, CL_JSB, CL_RET, CL_ILL} iclass_e;
  localparam logic [1:0] OP_R = 2'b00;
  localparam logic [1:0] OP_I = 2'b01;
  localparam logic [2:0] OP_SHF = 3'b100;
  localparam logic [2:0] OP_MEM = 3'b101;
  localparam logic [2:0] OP_BR = 3'b110;
  localparam logic [4:0] OP_JMP = 5'b11100;
  localparam logic [4:0] OP_JSB = 5'b11101;
  localparam logic [5:0] OP_RET = 6'b111100;
  localparam logic [1:0] FN_LDM = 2'b00;
  localparam logic [1:0] FN_STM = 2'b01;
  localparam logic [1:0] FN_BZ = 2'b00;
  localparam logic [1:0] FN_BC = 2'b01;
  localparam logic [1:0] FN_BNZ = 2'b10;
  localparam logic [3:0] ADD_SIGNED = 4'b0000;
  localparam logic [3:0] PC_STACK = 4'b1000;
  localparam logic [3:0] PC_CONST = 4'b0100;
  localparam logic [3:0] PC_OFFSET = 4'b0010;
  localparam logic [3:0] PC_PLUS1 = 4'b0001;
  localparam logic [2:0] RF_SHF = 3'b100;
  localparam logic [2:0] RF_MEM = 3'b010;
  localparam logic [2:0] RF_ALU = 3'b001;
  function automatic iclass_e decode(input logic [5:0] op);
    return op[5:4] == OP_R ? CL_R :
           op[5:4] == OP_I ? CL_I :
           op[5:3] == OP_SHF ? CL_SHF :
           op[5:3] == OP_MEM ? (op[2:1] == FN_LDM ? CL_LDM : op[2:1] == FN_STM ? CL_STM : CL_ILL) :
           op[5:3] == OP_BR ? CL_BR :
           op[5:1] == OP_JMP ? CL_JMP :
           op[5:1] == OP_JSB ? CL_JSB :
           op == OP_RET ? CL_RET : CL_ILL;
  endfunction
  function automatic logic br_taken(input logic [1:0] fn, input logic c, input logic z);
    return fn == FN_BZ ? z : fn == FN_BC ? c : fn == FN_BNZ ? !z : !c;
  endfunction
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction and data memory handshake bundle
interface multicycle_controller_if;
  logic imem_req;
  logic imem_ready;
  logic [5:0] instr;
  logic dmem_req;
  logic dmem_ready;
  logic mem_read;
  logic mem_write;
  modport master(output imem_req, dmem_req, mem_read, mem_write, input imem_ready, instr, dmem_ready);
  modport slave(input imem_req, dmem_req, mem_read, mem_write, output imem_ready, instr, dmem_ready);
endinterface

// File: rtl/multicycle_controller_stack_tracker.sv
// ctrl_stack_tracker: return-stack occupancy counter with full/empty and overflow/underflow detection
module ctrl_stack_tracker #(
  parameter int DEPTH = 8,
  parameter int SP_W = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_req_i,
  input  logic            pop_req_i,
  output logic            push_o,
  output logic            pop_o,
  output logic            err_o,
  output logic [SP_W-1:0] sp_level_o,
  output logic            full_o,
  output logic            empty_o
);
  logic [SP_W-1:0] sp_q, sp_d;
  assign full_o = sp_q == SP_W'(DEPTH);
  assign empty_o = sp_q == '0;
  assign push_o = push_req_i && !full_o;
  assign pop_o = pop_req_i && !empty_o;
  assign err_o = (push_req_i && full_o) || (pop_req_i && empty_o);
  assign sp_d = push_o ? sp_q + SP_W'(1) : pop_o ? sp_q - SP_W'(1) : sp_q;
  assign sp_level_o = sp_q;
  always_ff @(posedge clk) begin
    if (!rst_n) sp_q <= '0;
    else sp_q <= sp_d;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer for the 6-bit-opcode accumulator CPU
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 4,
  parameter int STACK_DEPTH = 8,
  parameter int SP_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_controller_if.master mem_if,
  input  logic                  alu_c_i,
  input  logic                  alu_z_i,
  input  logic                  shf_c_i,
  input  logic                  shf_z_i,
  output logic [ALU_OP_W-1:0]   alu_op_o,
  output logic                  sel_alusrc_reg_o,
  output logic                  sel_alusrc_const_o,
  output logic [3:0]            pc_sel_o,
  output logic                  pc_we_o,
  output logic                  ir_we_o,
  output logic [2:0]            rf_in_sel_o,
  output logic                  rf_rd2_sel_rd_o,
  output logic                  rf_we_o,
  output logic                  push_stack_o,
  output logic                  pop_stack_o,
  output logic                  c_flag_o,
  output logic                  z_flag_o,
  output logic [SP_W-1:0]       sp_level_o,
  output logic                  stack_full_o,
  output logic                  stack_empty_o,
  output logic                  stack_err_o,
  output logic                  illegal_instr_o
);
  state_e state_q, state_d;
  logic [5:0] ir_q;
  logic c_q, z_q;
  iclass_e cls;
  logic exec, hold, alu_cls, push_req, pop_req;
  assign cls = decode(ir_q);
  assign exec = rst_n && state_q == EXEC;
  assign hold = rst_n && (state_q == EXEC || state_q == MEM || state_q == WB);
  assign alu_cls = cls == CL_R || cls == CL_I;
  assign push_req = exec && cls == CL_JSB;
  assign pop_req = exec && cls == CL_RET;
  ctrl_stack_tracker #(.DEPTH(STACK_DEPTH), .SP_W(SP_W)) u_stack (
    .clk, .rst_n,
    .push_req_i(push_req), .pop_req_i(pop_req),
    .push_o(push_stack_o), .pop_o(pop_stack_o), .err_o(stack_err_o),
    .sp_level_o, .full_o(stack_full_o), .empty_o(stack_empty_o)
  );
  // Datapath selects stay stable from EXEC until the instruction retires
  assign alu_op_o = !hold ? '0 : alu_cls ? ALU_OP_W'(ir_q[3:1]) : ALU_OP_W'(ADD_SIGNED);
  assign sel_alusrc_reg_o = hold && cls == CL_R;
  assign sel_alusrc_const_o = hold && (cls == CL_I || cls == CL_LDM || cls == CL_STM);
  assign rf_in_sel_o = !hold ? 3'b000 : alu_cls ? RF_ALU : cls == CL_SHF ? RF_SHF : cls == CL_LDM ? RF_MEM : 3'b000;
  assign illegal_instr_o = exec && cls == CL_ILL;
  assign c_flag_o = c_q;
  assign z_flag_o = z_q;
  always_comb begin
    state_d = state_q;
    mem_if.imem_req = 1'b0;
    mem_if.dmem_req = 1'b0;
    mem_if.mem_read = 1'b0;
    mem_if.mem_write = 1'b0;
    ir_we_o = 1'b0;
    pc_we_o = 1'b0;
    pc_sel_o = 4'b0000;
    rf_we_o = 1'b0;
    rf_rd2_sel_rd_o = 1'b0;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          mem_if.imem_req = 1'b1;
          ir_we_o = mem_if.imem_ready;
          state_d = mem_if.imem_ready ? DECODE : FETCH;
        end
        DECODE: state_d = EXEC;
        EXEC: begin
          state_d = (alu_cls || cls == CL_SHF) ? WB : (cls == CL_LDM || cls == CL_STM) ? MEM : FETCH;
          pc_we_o = state_d == FETCH;
          pc_sel_o = !pc_we_o ? 4'b0000 :
                     cls == CL_BR ? (br_taken(ir_q[2:1], c_q, z_q) ? PC_OFFSET : PC_PLUS1) :
                     cls == CL_JMP ? PC_CONST :
                     cls == CL_JSB ? (push_stack_o ? PC_CONST : PC_PLUS1) :
                     cls == CL_RET ? (pop_stack_o ? PC_STACK : PC_PLUS1) : PC_PLUS1;
        end
        MEM: begin
          mem_if.dmem_req = 1'b1;
          mem_if.mem_read = cls == CL_LDM;
          mem_if.mem_write = cls == CL_STM;
          rf_rd2_sel_rd_o = cls == CL_STM;
          pc_we_o = mem_if.dmem_ready && cls == CL_STM;
          pc_sel_o = pc_we_o ? PC_PLUS1 : 4'b0000;
          state_d = !mem_if.dmem_ready ? MEM : cls == CL_STM ? FETCH : WB;
        end
        WB: begin
          rf_we_o = 1'b1;
          pc_we_o = 1'b1;
          pc_sel_o = PC_PLUS1;
          state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ir_q <= '0;
      c_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ir_we_o) ir_q <= mem_if.instr;
      if (exec && alu_cls) {c_q, z_q} <= {alu_c_i, alu_z_i};
      if (exec && cls == CL_SHF) {c_q, z_q} <= {shf_c_i, shf_z_i};
    end
  end
endmodule
